// File: rtl/ex_muldiv_ctrl_if.sv
// Request/response bundle between the execute stage and the M-extension controller.
interface ex_muldiv_ctrl_if #(
    parameter int XLEN = 32
);
    logic            req_valid_i;
    logic            req_ready_o;
    logic [2:0]      op_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic            flush_i;
    logic            resp_valid_o;
    logic [XLEN-1:0] resp_data_o;
    logic            resp_ready_i;
    logic            busy_o;

    modport master (
        output req_valid_i, op_i, rs1_data_i, rs2_data_i, flush_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_data_o, busy_o
    );

    modport slave (
        input  req_valid_i, op_i, rs1_data_i, rs2_data_i, flush_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_data_o, busy_o
    );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// Iterative RV32M multiply/divide controller (IDLE/CALC/DONE).
// Define MULDIV_FAST_MUL_EN to compute multiplies in a single cycle; divides stay iterative.
module ex_muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    ex_muldiv_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_MUL,
        OP_MULH,
        OP_MULHSU,
        OP_MULHU,
        OP_DIV,
        OP_DIVU,
        OP_REM,
        OP_REMU
    } op_e;

    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [5:0]      LastIter = 6'(XLEN - 1);

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;

    // Request decode: signedness, operand magnitudes and the two divide corner cases.
    op_e             op_in;
    logic [XLEN-1:0] rs1, rs2;
    logic            in_div, s1_sgn, s2_sgn, neg1, neg2, div_zero, div_ovf, accept;
    logic [XLEN-1:0] abs1, abs2;

    assign op_in    = op_e'(bus.op_i);
    assign rs1      = bus.rs1_data_i;
    assign rs2      = bus.rs2_data_i;
    assign in_div   = bus.op_i[2];
    assign s1_sgn   = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign s2_sgn   = op_in inside {OP_MULH, OP_DIV, OP_REM};
    assign neg1     = s1_sgn & rs1[XLEN-1];
    assign neg2     = s2_sgn & rs2[XLEN-1];
    assign abs1     = neg1 ? -rs1 : rs1;
    assign abs2     = neg2 ? -rs2 : rs2;
    assign div_zero = in_div & (rs2 == '0);
    assign div_ovf  = (op_in inside {OP_DIV, OP_REM}) & (rs1 == MinInt) & (rs2 == '1);
    assign accept   = bus.req_valid_i & bus.req_ready_o;

    logic            fast_mul;
    logic [XLEN-1:0] fast_res;
`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fa, fb;
    logic signed [2*XLEN-1:0] fp;

    assign fa       = {neg1, rs1};
    assign fb       = {neg2, rs2};
    assign fp       = (2*XLEN)'(fa) * (2*XLEN)'(fb);
    assign fast_mul = ~in_div;
    assign fast_res = (op_in == OP_MUL) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
`else
    assign fast_mul = 1'b0;
    assign fast_res = '0;
`endif

    // Sign-correct the raw magnitude result and pick the word the op asks for.
    function automatic logic [XLEN-1:0] pick_result(
        input op_e             op,
        input logic [XLEN-1:0] hi,
        input logic [XLEN-1:0] lo,
        input logic            neg,
        input logic            rneg
    );
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   res;
        prod = neg ? -{hi, lo} : {hi, lo};
        unique case (op)
            OP_MUL:                       res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              res = neg ? -lo : lo;
            default:                      res = rneg ? -hi : hi;
        endcase
        return res;
    endfunction

    logic [XLEN:0] mul_sum, rem_sh, rem_sub;
    logic          rem_ge;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        b_d      = b_q;
        result_d = result_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;

        mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        rem_sh  = {acc_q, lo_q[XLEN-1]};
        rem_sub = rem_sh - {1'b0, b_q};
        rem_ge  = ~rem_sub[XLEN];

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = op_in;
                    cnt_d   = '0;
                    acc_d   = '0;
                    lo_d    = abs1;
                    b_d     = abs2;
                    neg_d   = neg1 ^ neg2;
                    rneg_d  = neg1;
                    state_d = S_CALC;
                    if (div_zero) begin
                        state_d  = S_DONE;
                        result_d = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : rs1;
                    end else if (div_ovf) begin
                        state_d  = S_DONE;
                        result_d = (op_in == OP_DIV) ? MinInt : '0;
                    end else if (fast_mul) begin
                        state_d  = S_DONE;
                        result_d = fast_res;
                    end
                end
            end
            S_CALC: begin
                if (op_q[2]) begin
                    // Restoring division: quotient bits shift into lo, remainder lives in acc.
                    acc_d = rem_ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
                    lo_d  = {lo_q[XLEN-2:0], rem_ge};
                end else begin
                    acc_d = mul_sum[XLEN:1];
                    lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
                end
                if (cnt_q == LastIter) begin
                    state_d  = S_DONE;
                    result_d = pick_result(op_q, acc_d, lo_d, neg_q, rneg_q);
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DONE: begin
                if (bus.resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.flush_i) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
        end
    end

    assign bus.req_ready_o  = (state_q == S_IDLE) & ~bus.flush_i;
    assign bus.busy_o       = (state_q != S_IDLE);
    assign bus.resp_valid_o = (state_q == S_DONE);
    assign bus.resp_data_o  = bus.resp_valid_o ? result_q : '0;

endmodule
